// File: rtl/instruction_memory_responder_if.sv
// Fetch-side bus of the instruction memory responder: request/response
// handshakes plus the preload write port.
interface instruction_memory_responder_if;
   logic        request_valid;
   logic        request_ready;
   logic [31:0] request_address;
   logic        response_valid;
   logic        response_ready;
   logic [31:0] response_instruction;
   logic        response_error;
   logic        write_enable;
   logic [31:0] write_address;
   logic [31:0] write_data;

   // Fetch unit / preloader side
   modport master (
      output request_valid, request_address, response_ready,
             write_enable, write_address, write_data,
      input  request_ready, response_valid, response_instruction, response_error
   );

   // Responder side
   modport slave (
      input  request_valid, request_address, response_ready,
             write_enable, write_address, write_data,
      output request_ready, response_valid, response_instruction, response_error
   );
endinterface

// File: rtl/instruction_memory_responder.sv
// Instruction memory responder: one outstanding fetch at a time, fixed
// response latency, misaligned/out-of-range fetches answered with a NOP
// and an error flag. The storage array is preloadable at any time and is
// never cleared by reset.
module instruction_memory_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic                           CLK,
   input logic                           Reset,
   instruction_memory_responder_if.slave bus
);

   localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
   localparam logic [2:0]  COUNT_LOAD  = 3'(LATENCY - 1);
   localparam logic [31:0] NOP_WORD    = 32'h00000013;

   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  count;
   logic [2:0]  count_next;
   logic        running;
   logic        error_flag;
   logic [31:0] read_word;
   logic        accept;
   logic        request_bad;
   logic        write_ok;
   logic [AW-1:0] read_index;
   logic [AW-1:0] write_index;

   logic [31:0] mem [DEPTH];

   // Address decode for the fetch and preload ports
   always_comb begin
      read_index  = bus.request_address[AW+1:2];
      write_index = bus.write_address[AW+1:2];
      request_bad = (bus.request_address[1:0] != 2'b00) ||
                    (bus.request_address[31:2] >= DEPTH_WORDS);
      write_ok    = bus.write_enable && (bus.write_address[1:0] == 2'b00) &&
                    (bus.write_address[31:2] < DEPTH_WORDS);
      accept      = bus.request_valid && bus.request_ready;
   end

   // Storage array: preload writes and a registered read captured on
   // acceptance (old data wins against a same-edge write). No reset so the
   // contents survive it and the array maps onto block RAM.
   always_ff @(posedge CLK) begin
      if (write_ok) begin
         mem[write_index] <= bus.write_data;
      end
      if (accept) begin
         read_word <= mem[read_index];
      end
   end

   // State register, latency counter, error flag and post-reset ready gate
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         count      <= 3'd0;
         running    <= 1'b0;
         error_flag <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         running <= 1'b1;
         if (accept) begin
            error_flag <= request_bad;
         end
      end
   end

   // Next-state logic; WAIT leaves when the counter reaches its last step
   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY <= 1) begin
                  state_next = RESPOND;
                  count_next = 3'd0;
               end else begin
                  state_next = WAIT;
                  count_next = COUNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (count <= 3'd1) begin
               state_next = RESPOND;
               count_next = 3'd0;
            end else begin
               count_next = count - 3'd1;
            end
         end
         RESPOND: begin
            if (bus.response_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 3'd0;
         end
      endcase
   end

   // Outputs: ready only in IDLE once out of reset; response fields zero
   // unless a response is being presented
   always_comb begin
      bus.request_ready        = running && (state == IDLE);
      bus.response_valid       = (state == RESPOND);
      bus.response_instruction = 32'd0;
      bus.response_error       = 1'b0;
      if (state == RESPOND) begin
         bus.response_instruction = error_flag ? NOP_WORD : read_word;
         bus.response_error       = error_flag;
      end
   end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 8) share one
// stimulus; the LATENCY=2 instance carries the functional vectors.
module tb_instruction_memory_responder;

   localparam int DEPTH = 256;

   logic        CLK;
   logic        Reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        resp_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   instruction_memory_responder_if if_l2 ();
   instruction_memory_responder_if if_l1 ();
   instruction_memory_responder_if if_l8 ();

   assign if_l2.request_valid = req_valid;
   assign if_l2.request_address = req_addr;
   assign if_l2.response_ready = resp_ready;
   assign if_l2.write_enable = wr_en;
   assign if_l2.write_address = wr_addr;
   assign if_l2.write_data = wr_data;
   assign if_l1.request_valid = req_valid;
   assign if_l1.request_address = req_addr;
   assign if_l1.response_ready = resp_ready;
   assign if_l1.write_enable = wr_en;
   assign if_l1.write_address = wr_addr;
   assign if_l1.write_data = wr_data;
   assign if_l8.request_valid = req_valid;
   assign if_l8.request_address = req_addr;
   assign if_l8.response_ready = resp_ready;
   assign if_l8.write_enable = wr_en;
   assign if_l8.write_address = wr_addr;
   assign if_l8.write_data = wr_data;

   instruction_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
      .CLK(CLK), .Reset(Reset), .bus(if_l2.slave));
   instruction_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
      .CLK(CLK), .Reset(Reset), .bus(if_l1.slave));
   instruction_memory_responder #(.DEPTH(DEPTH), .LATENCY(8)) dut_l8 (
      .CLK(CLK), .Reset(Reset), .bus(if_l8.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      int          hold;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      @(posedge CLK); #1;
      wr_en = 1'b0;
      $display("write addr=%h data=%h", addr, data);
   endtask

   task automatic wait_ready();
      int i;
      i = 0;
      while (!if_l2.request_ready && i < 40) begin
         @(posedge CLK); #1;
         i++;
      end
      check("ready_wait", 32'(if_l2.request_ready), 32'd1);
   endtask

   // Issue one fetch on the LATENCY=2 responder, hold the response for
   // 'hold' cycles, then consume it. Latency counts the accepting edge as 1.
   task automatic do_request(input logic [31:0] addr, input int hold,
                             output logic [31:0] instr, output logic err, output int lat);
      int n;
      wait_ready();
      req_valid = 1'b1; req_addr = addr;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      check("ready_low_after_accept", 32'(if_l2.request_ready), 32'd0);
      n = 1;
      while (!if_l2.response_valid && n < 20) begin
         check("instr_zero_while_invalid", if_l2.response_instruction, 32'd0);
         @(posedge CLK); #1;
         n++;
      end
      lat = n;
      instr = if_l2.response_instruction;
      err = if_l2.response_error;
      check("valid_seen", 32'(if_l2.response_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         check("hold_valid", 32'(if_l2.response_valid), 32'd1);
         check("hold_instr", if_l2.response_instruction, instr);
         check("hold_err", 32'(if_l2.response_error), 32'(err));
         check("hold_ready_low", 32'(if_l2.request_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge CLK); #1;
      resp_ready = 1'b0;
      check("consumed_valid_low", 32'(if_l2.response_valid), 32'd0);
      check("consumed_instr_zero", if_l2.response_instruction, 32'd0);
      check("consumed_err_zero", 32'(if_l2.response_error), 32'd0);
      check("consumed_ready_high", 32'(if_l2.request_ready), 32'd1);
      $display("fetch addr=%h instr=%h err=%0d latency=%0d hold=%0d", addr, instr, err, lat, hold);
   endtask

   task automatic drain_all();
      int i;
      resp_ready = 1'b1;
      i = 0;
      while (!(if_l1.request_ready && if_l2.request_ready && if_l8.request_ready) && i < 40) begin
         @(posedge CLK); #1;
         i++;
      end
      resp_ready = 1'b0;
      check("all_ready", 32'(if_l1.request_ready && if_l2.request_ready && if_l8.request_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] instr;
      logic        err;
      int          lat;
      int          lat1, lat2, lat8;
      logic [31:0] ins1, ins2, ins8;
      int          seen;

      vecs[0] = '{32'h00000000, 0, 32'h00500093, 1'b0};
      vecs[1] = '{32'h00000004, 5, 32'h00A00113, 1'b0};
      vecs[2] = '{32'h00000008, 0, 32'h002081B3, 1'b0};
      vecs[3] = '{32'h000003FC, 1, 32'h0000006F, 1'b0};
      vecs[4] = '{32'h00000400, 0, 32'h00000013, 1'b1};
      vecs[5] = '{32'h00000006, 2, 32'h00000013, 1'b1};
      vecs[6] = '{32'h00000001, 0, 32'h00000013, 1'b1};
      vecs[7] = '{32'hFFFFFFFC, 0, 32'h00000013, 1'b1};

      Reset = 1'b1;
      req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
      #3;
      check("reset_ready", 32'(if_l2.request_ready), 32'd0);
      check("reset_valid", 32'(if_l2.response_valid), 32'd0);
      check("reset_instr", if_l2.response_instruction, 32'd0);
      check("reset_err", 32'(if_l2.response_error), 32'd0);

      // Preload word 0 while reset is still asserted
      @(posedge CLK); #1;
      write_word(32'h0, 32'h00500093);
      #2 Reset = 1'b0;
      #1;
      check("ready_before_first_edge", 32'(if_l2.request_ready), 32'd0);
      @(posedge CLK); #1;
      check("ready_after_first_edge", 32'(if_l2.request_ready), 32'd1);

      write_word(32'h4, 32'h00A00113);
      write_word(32'h8, 32'h002081B3);
      write_word(32'h3FC, 32'h0000006F);
      // Both of these must be ignored; either would land on word 0 if decoded loosely
      write_word(32'h400, 32'hBAD0BAD0);
      write_word(32'h2, 32'hBAD1BAD1);

      // Latency across the three instances from one shared accept edge
      drain_all();
      req_valid = 1'b1; req_addr = 32'h0;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      lat1 = 0; lat2 = 0; lat8 = 0;
      ins1 = 32'd0; ins2 = 32'd0; ins8 = 32'd0;
      for (int n = 1; n <= 12; n++) begin
         if (if_l1.response_valid && lat1 == 0) begin lat1 = n; ins1 = if_l1.response_instruction; end
         if (if_l2.response_valid && lat2 == 0) begin lat2 = n; ins2 = if_l2.response_instruction; end
         if (if_l8.response_valid && lat8 == 0) begin lat8 = n; ins8 = if_l8.response_instruction; end
         @(posedge CLK); #1;
      end
      $display("latency L1=%0d L2=%0d L8=%0d", lat1, lat2, lat8);
      check("latency_1", 32'(lat1), 32'd1);
      check("latency_2", 32'(lat2), 32'd2);
      check("latency_8", 32'(lat8), 32'd8);
      check("instr_l1", ins1, 32'h00500093);
      check("instr_l2", ins2, 32'h00500093);
      check("instr_l8", ins8, 32'h00500093);
      drain_all();

      // Table of fetches on the LATENCY=2 instance
      for (int v = 0; v < 8; v++) begin
         do_request(vecs[v].addr, vecs[v].hold, instr, err, lat);
         check("vec_instr", instr, vecs[v].instr);
         check("vec_err", 32'(err), 32'(vecs[v].err));
         check("vec_latency", 32'(lat), 32'd2);
      end

      // Same-edge write against an accepted fetch returns the old word
      wait_ready();
      req_valid = 1'b1; req_addr = 32'h8;
      wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h11111111;
      @(posedge CLK); #1;
      req_valid = 1'b0; wr_en = 1'b0;
      @(posedge CLK); #1;
      check("same_edge_valid", 32'(if_l2.response_valid), 32'd1);
      check("same_edge_old_word", if_l2.response_instruction, 32'h002081B3);
      resp_ready = 1'b1; @(posedge CLK); #1; resp_ready = 1'b0;
      do_request(32'h8, 0, instr, err, lat);
      check("same_edge_new_word", instr, 32'h11111111);

      // Write during WAIT does not disturb the in-flight response
      wait_ready();
      req_valid = 1'b1; req_addr = 32'h0;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      write_word(32'h0, 32'hDEADBEEF);
      check("wait_write_valid", 32'(if_l2.response_valid), 32'd1);
      check("wait_write_old_word", if_l2.response_instruction, 32'h00500093);
      resp_ready = 1'b1; @(posedge CLK); #1; resp_ready = 1'b0;
      do_request(32'h0, 0, instr, err, lat);
      check("wait_write_new_word", instr, 32'hDEADBEEF);

      // Reset in WAIT aborts the fetch
      wait_ready();
      req_valid = 1'b1; req_addr = 32'h4;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check("abort_wait_ready", 32'(if_l2.request_ready), 32'd0);
      check("abort_wait_valid", 32'(if_l2.response_valid), 32'd0);
      check("abort_wait_instr", if_l2.response_instruction, 32'd0);
      @(posedge CLK); #3;
      Reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         if (if_l2.response_valid) seen++;
      end
      check("abort_wait_no_response", 32'(seen), 32'd0);
      do_request(32'h4, 0, instr, err, lat);
      check("post_reset_word1", instr, 32'h00A00113);

      // Reset in RESPOND drops the response immediately
      wait_ready();
      req_valid = 1'b1; req_addr = 32'h4;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(posedge CLK); #1;
      check("respond_before_reset", 32'(if_l2.response_valid), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("abort_respond_valid", 32'(if_l2.response_valid), 32'd0);
      check("abort_respond_instr", if_l2.response_instruction, 32'd0);
      @(posedge CLK); #3;
      Reset = 1'b0;
      @(posedge CLK); #1;
      check("abort_respond_idle", 32'(if_l2.request_ready), 32'd1);
      check("abort_respond_no_valid", 32'(if_l2.response_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
